mem_if_streamer: RTL and testbench
==================================

Name: mem_if_streamer

Overview:
- Host-side driver for the accelerator memory interface; it is the initiator on the port the accelerator responds to.
- Accepts high-level commands: LOAD, RUN, READ, FINISH.
- Drives start, eoc, mem_rd_wrt, the namespace plus per-lane {peId,valid} control word, and write data.
- Captures read-back lanes after the fixed interface latency into a credit-protected FIFO.
- Sits between the DMA/AXI wrapper and the accelerator top.

Parameters:
- NUM_LANES, 16, memory lanes per beat.
- DATA_LEN, 16, bits per lane.
- LOG_NS, 2, namespace field width.
- LOG_PE_LANES, 1, peId bits per lane; NUM_PE_LANES = 1<<LOG_PE_LANES.
- READ_LATENCY, 4, cycles from a read beat issued to valid mem_data_output; must be >=1.
- FIFO_DEPTH, 8, read-return FIFO entries; power of two, >= READ_LATENCY.
- CNT_W, 16, width of beat and iteration counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command handshake.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=LOAD, 1=RUN, 2=READ, 3=FINISH.
- cmd_ns  in  LOG_NS  namespace for LOAD/READ.
- cmd_count  in  CNT_W  beats for LOAD/READ; iterations for RUN; 0 treated as 1.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accept.
- wr_data  in  NUM_LANES*DATA_LEN  write beat.
- wr_lane_en  in  NUM_LANES  per-lane valid.
- wr_pe_sel  in  NUM_LANES*LOG_PE_LANES  per-lane peId.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  read beat accept.
- rd_data  out  NUM_LANES*DATA_LEN  read beat.
- mem_start  out  1  one-cycle start pulse.
- mem_eoc  out  1  one-cycle end-of-compute pulse.
- mem_rd_wrt  out  1  1=read beat.
- mem_ctrl  out  LOG_NS+(LOG_PE_LANES+1)*NUM_LANES  memory control word.
- mem_data_in  out  NUM_LANES*DATA_LEN  write data to accelerator.
- mem_data_out  in  NUM_LANES*DATA_LEN  read data from accelerator.
- mem_eol  in  1  end-of-loop pulse.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rstn low, asynchronous, usable mid-operation):
  - FSM returns to IDLE; all counters and the FIFO are cleared.
  - mem_start, mem_eoc, mem_rd_wrt, mem_ctrl, mem_data_in, rd_valid, wr_ready and busy are 0.
  - Any in-flight read data is discarded.
- mem_ctrl layout:
  - bits[LOG_NS-1:0] = namespace.
  - Lane i field at offset LOG_NS+(LOG_PE_LANES+1)*i: bit0 = valid, upper LOG_PE_LANES bits = peId.
  - mem_ctrl is all zeros in any cycle with no beat.
- All mem_* outputs are registered: one cycle from the FSM decision to the pin.
- FSM states: IDLE, LOAD, START, WAIT_EOL, READ, DRAIN, EOC.
- IDLE:
  - A command is accepted on cmd_valid & cmd_ready.
  - The FSM latches ns/count (0 becomes 1) and moves to LOAD, START, READ or EOC according to cmd_op.
- LOAD:
  - wr_ready=1.
  - On each wr_valid & wr_ready, issue one beat: mem_rd_wrt=0, lane valid=wr_lane_en[i], peId=wr_pe_sel lane i, data=wr_data; decrement the beat counter.
  - No wr_valid gives an idle cycle (ctrl=0).
  - After the last beat, go to IDLE.
- START: drive mem_start for exactly 1 cycle, then go to WAIT_EOL.
- WAIT_EOL:
  - mem_eol is sampled only in this state; eol arriving in the START cycle is ignored.
  - On mem_eol, decrement the iteration counter; if nonzero go to START, else go to IDLE.
  - No timeout.
- READ:
  - Issue a read beat with all lanes valid, mem_rd_wrt=1, peId = beat index mod NUM_PE_LANES (same for all lanes).
  - A beat is issued only when credits > 0. Credits = FIFO_DEPTH - fifo_count - in_flight.
  - A READ_LATENCY-deep valid shift register tracks in-flight beats.
  - Data arriving with the shifted valid is pushed to the FIFO. A push and a pop in the same cycle leave the count unchanged.
  - Credit is never negative, so FIFO overflow is impossible; a bench assertion covers this.
  - After the last beat is issued, go to DRAIN.
- DRAIN: wait until in_flight==0, then go to IDLE. The FIFO may still hold data; rd_valid stays independent of the FSM.
- rd_valid = FIFO non-empty; the FIFO pops on rd_valid & rd_ready. rd_data is the head entry, stable while rd_valid & !rd_ready.
- EOC: drive mem_eoc for 1 cycle, then go to IDLE.
- Counters wrap naturally at CNT_W. There is no other wrap condition, since count >= 1.

Optional Feature:
- Macro: MEM_IF_STREAMER_PERF_EN.
- When defined:
  - Adds output perf_cycles [31:0].
  - Cleared on accepting a RUN command.
  - Increments each cycle in START or WAIT_EOL.
  - Saturates at all-ones; holds its value until the next RUN.
- When undefined: the port and the counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: rstn low mid-READ with 3 beats in flight -> all outputs 0 at the next edge; after release, rd_valid stays 0 and cmd_ready=1.
- LOAD: ns=1, count=3, wr_valid gapped one cycle after beat 1 -> exactly 3 beats with mem_rd_wrt=0, mem_ctrl[1:0]=1, one cycle with ctrl=0 in the gap, return to IDLE.
- RUN: count=2, mem_eol driven 5 cycles after each start, plus one spurious eol in the start cycle -> exactly 2 mem_start pulses; the spurious eol is ignored; busy drops after the second eol.
- READ backpressure: FIFO_DEPTH=8, READ_LATENCY=4, count=20, rd_ready low for 30 cycles -> issue stalls after 8 beats; no overflow; all 20 beats delivered in order with peId alternating 0,1.
- FINISH: mem_eoc is a single-cycle pulse and cmd_ready returns the cycle after.
- PERF (macro on): RUN count=1, eol 10 cycles after start -> perf_cycles = 11 at return to IDLE.

Source files
------------

// File: rtl/mem_if_streamer_if.sv
// -----------------------------------------------------------------------------
// mem_if_streamer_if
// Bus between the host-side streamer and the accelerator memory port.
//   mem_start    : one-cycle start pulse            (master -> slave)
//   mem_eoc      : one-cycle end-of-compute pulse   (master -> slave)
//   mem_rd_wrt   : 1 = read beat, 0 = write beat    (master -> slave)
//   mem_ctrl     : namespace + per-lane {peId,valid} (master -> slave)
//   mem_data_in  : write data                       (master -> slave)
//   mem_data_out : read data                        (slave -> master)
//   mem_eol      : end-of-loop pulse                (slave -> master)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface mem_if_streamer_if #(
    parameter int NUM_LANES    = 16,
    parameter int DATA_LEN     = 16,
    parameter int LOG_NS       = 2,
    parameter int LOG_PE_LANES = 1
);
    localparam int CTRL_W = LOG_NS + (LOG_PE_LANES + 1) * NUM_LANES;
    localparam int BEAT_W = NUM_LANES * DATA_LEN;

    logic              mem_start;
    logic              mem_eoc;
    logic              mem_rd_wrt;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [BEAT_W-1:0] mem_data_in;
    logic [BEAT_W-1:0] mem_data_out;
    logic              mem_eol;

    modport master (
        output mem_start, mem_eoc, mem_rd_wrt, mem_ctrl, mem_data_in,
        input  mem_data_out, mem_eol
    );

    modport slave (
        input  mem_start, mem_eoc, mem_rd_wrt, mem_ctrl, mem_data_in,
        output mem_data_out, mem_eol
    );
endinterface

// File: rtl/mem_if_streamer.sv
// -----------------------------------------------------------------------------
// mem_if_streamer
// Host-side initiator for the accelerator memory interface. Takes LOAD / RUN /
// READ / FINISH commands, issues registered beats and pulses on the mem bus, and
// captures read data returning READ_LATENCY cycles later into a FIFO that is
// protected by credits, so it can never overflow.
//
// Ports
//   clk, rstn               : clock, asynchronous active-low reset
//   cmd_valid/ready/op/ns/count : command handshake (ready only in IDLE)
//   wr_valid/ready/data/lane_en/pe_sel : write beats consumed during LOAD
//   rd_valid/ready/data     : read-return stream (FIFO head)
//   mem                     : mem_if_streamer_if.master bus to the accelerator
//   busy                    : high whenever the FSM is not IDLE
//   perf_cycles             : START+WAIT_EOL cycle count of the last RUN
//                             (only when MEM_IF_STREAMER_PERF_EN is defined)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_if_streamer #(
    parameter int NUM_LANES    = 16,
    parameter int DATA_LEN     = 16,
    parameter int LOG_NS       = 2,
    parameter int LOG_PE_LANES = 1,
    parameter int READ_LATENCY = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [LOG_NS-1:0]                 cmd_ns,
    input  logic [CNT_W-1:0]                  cmd_count,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [NUM_LANES*DATA_LEN-1:0]     wr_data,
    input  logic [NUM_LANES-1:0]              wr_lane_en,
    input  logic [NUM_LANES*LOG_PE_LANES-1:0] wr_pe_sel,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [NUM_LANES*DATA_LEN-1:0]     rd_data,
    mem_if_streamer_if.master                 mem,
    output logic                              busy
`ifdef MEM_IF_STREAMER_PERF_EN
    ,
    output logic [31:0]                       perf_cycles
`endif
);
    localparam int CTRL_W = LOG_NS + (LOG_PE_LANES + 1) * NUM_LANES;
    localparam int LANE_W = LOG_PE_LANES + 1;
    localparam int BEAT_W = NUM_LANES * DATA_LEN;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int OCC_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_READ = 2'd2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_WAIT_EOL = 3'd3;
    localparam logic [2:0] S_READ     = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;
    localparam logic [2:0] S_EOC      = 3'd6;

    logic [2:0]              state, state_d;
    logic [LOG_NS-1:0]       ns_q, ns_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LOG_PE_LANES-1:0] idx_q, idx_d;
    logic                    start_d, eoc_d, rd_wrt_d;
    logic [CTRL_W-1:0]       ctrl_d;
    logic [BEAT_W-1:0]       data_d;

    // sr[i] marks a read beat whose data is due READ_LATENCY-1-i cycles later;
    // sr[READ_LATENCY-1] lines up with valid mem_data_out.
    logic [READ_LATENCY-1:0] sr;
    logic [BEAT_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [PTR_W:0]          fifo_cnt;
    logic [OCC_W-1:0]        in_flight;
    logic                    cmd_fire, wr_fire, rd_issue, last, push, pop;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wr_ready  = (state == S_LOAD);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign wr_fire   = wr_valid & wr_ready;
    assign last      = (cnt_q == CNT_W'(1));
    assign push      = sr[READ_LATENCY-1];
    assign rd_valid  = (fifo_cnt != '0);
    assign pop       = rd_valid & rd_ready;
    assign rd_data   = fifo_mem[rd_ptr];

    // Beats in flight: the registered pin stage plus the latency pipe.
    always_comb begin
        in_flight = OCC_W'(mem.mem_rd_wrt);
        for (int i = 0; i < READ_LATENCY; i++)
            in_flight = in_flight + OCC_W'(sr[i]);
    end

    // A read beat only goes out while FIFO entries plus in-flight beats
    // leave room, so every returning beat has a slot waiting for it.
    assign rd_issue = (state == S_READ) &&
                      ((OCC_W'(fifo_cnt) + in_flight) < OCC_W'(FIFO_DEPTH));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state;
        ns_d     = ns_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        start_d  = 1'b0;
        eoc_d    = 1'b0;
        rd_wrt_d = 1'b0;
        ctrl_d   = '0;
        data_d   = '0;
        case (state)
            S_IDLE: if (cmd_fire) begin
                ns_d  = cmd_ns;
                cnt_d = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                idx_d = '0;
                case (cmd_op)
                    OP_LOAD: state_d = S_LOAD;
                    OP_RUN:  state_d = S_START;
                    OP_READ: state_d = S_READ;
                    default: state_d = S_EOC;
                endcase
            end
            S_LOAD: if (wr_fire) begin
                ctrl_d[LOG_NS-1:0] = ns_q;
                for (int i = 0; i < NUM_LANES; i++)
                    ctrl_d[LOG_NS + LANE_W*i +: LANE_W] =
                        {wr_pe_sel[i*LOG_PE_LANES +: LOG_PE_LANES], wr_lane_en[i]};
                data_d = wr_data;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last) state_d = S_IDLE;
            end
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT_EOL;
            end
            S_WAIT_EOL: if (mem.mem_eol) begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = last ? S_IDLE : S_START;
            end
            S_READ: if (rd_issue) begin
                rd_wrt_d           = 1'b1;
                ctrl_d[LOG_NS-1:0] = ns_q;
                for (int i = 0; i < NUM_LANES; i++)
                    ctrl_d[LOG_NS + LANE_W*i +: LANE_W] = {idx_q, 1'b1};
                cnt_d = cnt_q - CNT_W'(1);
                idx_d = idx_q + 1'b1;
                if (last) state_d = S_DRAIN;
            end
            S_DRAIN: if (in_flight == '0) state_d = S_IDLE;
            S_EOC: begin
                eoc_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            ns_q            <= '0;
            cnt_q           <= '0;
            idx_q           <= '0;
            mem.mem_start   <= 1'b0;
            mem.mem_eoc     <= 1'b0;
            mem.mem_rd_wrt  <= 1'b0;
            mem.mem_ctrl    <= '0;
            mem.mem_data_in <= '0;
            sr              <= '0;
        end else begin
            // NOTE: state is written with non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state           <= state_d;
            ns_q            <= ns_d;
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            mem.mem_start   <= start_d;
            mem.mem_eoc     <= eoc_d;
            mem.mem_rd_wrt  <= rd_wrt_d;
            mem.mem_ctrl    <= ctrl_d;
            mem.mem_data_in <= data_d;
            for (int i = READ_LATENCY - 1; i > 0; i--)
                sr[i] <= sr[i-1];
            sr[0] <= mem.mem_rd_wrt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only meaningful
    // below fifo_cnt, and that count is reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem.mem_data_out;
    end

`ifdef MEM_IF_STREAMER_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            perf_cycles <= '0;
        else if (cmd_fire && cmd_op == OP_RUN)
            perf_cycles <= '0;
        else if ((state == S_START || state == S_WAIT_EOL) && perf_cycles != '1)
            perf_cycles <= perf_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mem_if_streamer.sv
`timescale 1ns/1ps

module tb_mem_if_streamer;
    localparam int NL = 16, DL = 16, NS = 2, PL = 1, L = 4, D = 8, CW = 16;
    localparam int BW = NL * DL;
    localparam int CTRL_W = NS + (PL + 1) * NL;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [NS-1:0]     cmd_ns;
    logic [CW-1:0]     cmd_count;
    logic              wr_valid, wr_ready;
    logic [BW-1:0]     wr_data;
    logic [NL-1:0]     wr_lane_en;
    logic [NL*PL-1:0]  wr_pe_sel;
    logic              rd_valid, rd_ready;
    logic [BW-1:0]     rd_data;
    logic              busy;
`ifdef MEM_IF_STREAMER_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    mem_if_streamer_if #(.NUM_LANES(NL), .DATA_LEN(DL), .LOG_NS(NS), .LOG_PE_LANES(PL)) mif ();

    mem_if_streamer #(
        .NUM_LANES(NL), .DATA_LEN(DL), .LOG_NS(NS), .LOG_PE_LANES(PL),
        .READ_LATENCY(L), .FIFO_DEPTH(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ns(cmd_ns), .cmd_count(cmd_count),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_lane_en(wr_lane_en), .wr_pe_sel(wr_pe_sel),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .mem(mif),
        .busy(busy)
`ifdef MEM_IF_STREAMER_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accelerator model: each lane of a read reply encodes the lane's peId
    // from mem_ctrl, the lane number and the running read-beat number.
    function automatic logic [BW-1:0] accel_word(input logic [CTRL_W-1:0] ctrl, input int k);
        logic [BW-1:0] r;
        for (int j = 0; j < NL; j++)
            r[j*DL +: DL] = {3'b000, ctrl[NS + 2*j + 1], 4'(j), 8'(k)};
        return r;
    endfunction

    function automatic logic [BW-1:0] exp_rd(input int i);
        logic [BW-1:0] r;
        for (int j = 0; j < NL; j++)
            r[j*DL +: DL] = {4'(i % 2), 4'(j), 8'(i)};
        return r;
    endfunction

    int                n_start = 0;
    int                n_eoc = 0;
    int                n_rbeat = 0;
    int                n_pop = 0;
    logic              ovf_seen = 1'b0;
    logic [CTRL_W-1:0] rd_ctrl_log [64];
    logic [L-1:0]      p_vld = '0;
    logic [BW-1:0]     p_dat [L];

    assign mif.mem_data_out = p_vld[L-1] ? p_dat[L-1] : {16{16'hDEAD}};

    always @(posedge clk) begin
        if (mif.mem_start) n_start <= n_start + 1;
        if (mif.mem_eoc)   n_eoc   <= n_eoc + 1;
        if (rd_valid && rd_ready) n_pop <= n_pop + 1;
        if (mif.mem_rd_wrt) begin
            if (n_rbeat < 64) rd_ctrl_log[n_rbeat] <= mif.mem_ctrl;
            n_rbeat <= n_rbeat + 1;
        end
        p_vld[0] <= mif.mem_rd_wrt;
        p_dat[0] <= accel_word(mif.mem_ctrl, n_rbeat);
        for (int j = 1; j < L; j++) begin
            p_vld[j] <= p_vld[j-1];
            p_dat[j] <= p_dat[j-1];
        end
        fifo_no_overflow: assert (n_rbeat - n_pop <= D) else ovf_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s0, e0, r0, got;
        cmd_valid = 0; cmd_op = 0; cmd_ns = 0; cmd_count = 0;
        wr_valid = 0; wr_data = '0; wr_lane_en = '0; wr_pe_sel = '0;
        rd_ready = 0; mif.mem_eol = 0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_ctrl", 256'(mif.mem_ctrl), 256'(0));
        rstn = 1;
        step();
        check("rst_cmd_ready", 256'(cmd_ready), 256'(1));
        check("rst_rd_valid", 256'(rd_valid), 256'(0));
        check("rst_wr_ready", 256'(wr_ready), 256'(0));

        // ---------------- LOAD ns=1 count=3 with a gap ----------------
        cmd_valid = 1; cmd_op = 2'd0; cmd_ns = 2'd1; cmd_count = 16'd3;
        step();
        cmd_valid = 0;
        check("load_busy", 256'(busy), 256'(1));
        check("load_wr_ready", 256'(wr_ready), 256'(1));
        wr_valid = 1; wr_lane_en = 16'h0005; wr_pe_sel = 16'h0004; wr_data = {16{16'h1111}};
        step();
        wr_valid = 0;
        check("load_b1_ctrl", 256'(mif.mem_ctrl), 256'(34'h0_0000_00C5));
        check("load_b1_rdwrt", 256'(mif.mem_rd_wrt), 256'(0));
        check("load_b1_data", mif.mem_data_in, {16{16'h1111}});
        step();
        check("load_gap_ctrl", 256'(mif.mem_ctrl), 256'(0));
        wr_valid = 1; wr_lane_en = 16'h8000; wr_pe_sel = 16'h8000; wr_data = {16{16'h2222}};
        step();
        check("load_b2_ctrl", 256'(mif.mem_ctrl), 256'(34'h3_0000_0001));
        check("load_b2_data", mif.mem_data_in, {16{16'h2222}});
        wr_lane_en = 16'hFFFF; wr_pe_sel = 16'h0000; wr_data = {16{16'h3333}};
        step();
        wr_valid = 0;
        check("load_b3_ctrl", 256'(mif.mem_ctrl), 256'(34'h1_5555_5555));
        check("load_b3_data", mif.mem_data_in, {16{16'h3333}});
        check("load_done_ready", 256'(cmd_ready), 256'(1));
        step();
        check("load_after_ctrl", 256'(mif.mem_ctrl), 256'(0));

        // ---------------- RUN count=2, spurious eol in START ----------------
        s0 = n_start;
        cmd_valid = 1; cmd_op = 2'd1; cmd_count = 16'd2;
        step();
        cmd_valid = 0;
        mif.mem_eol = 1;
        step();
        mif.mem_eol = 0;
        check("run_start_pin", 256'(mif.mem_start), 256'(1));
        repeat (4) step();
        check("run_single_pulse", 256'(n_start - s0), 256'(1));
        mif.mem_eol = 1;
        step();
        mif.mem_eol = 0;
        check("run_busy_mid", 256'(busy), 256'(1));
        repeat (5) step();
        check("run_busy_pre_eol", 256'(busy), 256'(1));
        mif.mem_eol = 1;
        step();
        mif.mem_eol = 0;
        check("run_busy_done", 256'(busy), 256'(0));
        check("run_start_count", 256'(n_start - s0), 256'(2));

        // ---------------- READ count=20 with backpressure ----------------
        r0 = n_rbeat;
        cmd_valid = 1; cmd_op = 2'd2; cmd_ns = 2'd2; cmd_count = 16'd20;
        step();
        cmd_valid = 0;
        repeat (30) step();
        check("rd_stall_beats", 256'(n_rbeat - r0), 256'(8));
        check("rd_stall_valid", 256'(rd_valid), 256'(1));
        check("rd_stall_head", rd_data, exp_rd(0));
        rd_ready = 1;
        got = 0;
        for (int c = 0; c < 300 && got < 20; c++) begin
            if (rd_valid) begin
                check($sformatf("rd_beat%0d", got), rd_data, exp_rd(got));
                got++;
            end
            step();
        end
        check("rd_all_delivered", 256'(got), 256'(20));
        check("rd_issued", 256'(n_rbeat - r0), 256'(20));
        for (int i = 0; i < 20; i++)
            check($sformatf("rd_ctrl%0d", i), 256'(rd_ctrl_log[r0 + i]),
                  (i % 2 == 1) ? 256'(34'h3_FFFF_FFFE) : 256'(34'h1_5555_5556));
        check("rd_no_overflow", 256'(ovf_seen), 256'(0));
        repeat (2) step();
        check("rd_busy_done", 256'(busy), 256'(0));
        check("rd_fifo_empty", 256'(rd_valid), 256'(0));
        rd_ready = 0;

        // ---------------- FINISH ----------------
        e0 = n_eoc;
        cmd_valid = 1; cmd_op = 2'd3;
        step();
        cmd_valid = 0;
        check("fin_ready_low", 256'(cmd_ready), 256'(0));
        check("fin_eoc_pre", 256'(mif.mem_eoc), 256'(0));
        step();
        check("fin_eoc_pulse", 256'(mif.mem_eoc), 256'(1));
        check("fin_ready_back", 256'(cmd_ready), 256'(1));
        step();
        check("fin_eoc_post", 256'(mif.mem_eoc), 256'(0));
        check("fin_eoc_count", 256'(n_eoc - e0), 256'(1));

`ifdef MEM_IF_STREAMER_PERF_EN
        // ---------------- PERF: RUN count=1, eol 10 cycles after START ----------------
        cmd_valid = 1; cmd_op = 2'd1; cmd_count = 16'd1;
        step();
        cmd_valid = 0;
        repeat (10) step();
        mif.mem_eol = 1;
        step();
        mif.mem_eol = 0;
        check("perf_idle", 256'(busy), 256'(0));
        check("perf_cycles", 256'(perf_cycles), 256'(11));
`endif

        // ---------------- reset in the middle of READ ----------------
        cmd_valid = 1; cmd_op = 2'd2; cmd_ns = 2'd0; cmd_count = 16'd10;
        step();
        cmd_valid = 0;
        repeat (3) step();
        check("mrst_reading", 256'(mif.mem_rd_wrt), 256'(1));
        #2 rstn = 0;
        #1;
        check("mrst_start", 256'(mif.mem_start), 256'(0));
        check("mrst_eoc", 256'(mif.mem_eoc), 256'(0));
        check("mrst_rdwrt", 256'(mif.mem_rd_wrt), 256'(0));
        check("mrst_ctrl", 256'(mif.mem_ctrl), 256'(0));
        check("mrst_data_in", mif.mem_data_in, 256'(0));
        check("mrst_rd_valid", 256'(rd_valid), 256'(0));
        check("mrst_wr_ready", 256'(wr_ready), 256'(0));
        check("mrst_busy", 256'(busy), 256'(0));
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        repeat (8) step();
        check("mrst_after_rd_valid", 256'(rd_valid), 256'(0));
        check("mrst_after_ready", 256'(cmd_ready), 256'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
